// File: rtl/cv32e41s_pkg.sv
// Shared types for the WB trace FIFO slice: the EX/WB pipeline view it consumes
// and the trace record it produces.
package cv32e41s_pkg;

  localparam int unsigned TRACE_SEQ_W_MAX  = 16;
  localparam int unsigned TRACE_HART_W     = 4;
  localparam int unsigned TRACE_DROP_CNT_W = 16;

  typedef struct packed {
    logic [31:0] rdata;
  } obi_inst_resp_t;

  typedef struct packed {
    obi_inst_resp_t bus_resp;
  } inst_resp_t;

  typedef struct packed {
    logic        instr_valid;
    logic [31:0] pc;
    inst_resp_t  instr;
    logic        illegal_insn;
  } ex_wb_pipe_t;

  // seq is sized for the widest counter; narrower counters are zero-extended
  typedef struct packed {
    logic [TRACE_SEQ_W_MAX-1:0] seq;
    logic [31:0]                pc;
    logic [31:0]                instr;
    logic                       illegal;
    logic [TRACE_HART_W-1:0]    hart;
    logic                       gap;
  } trace_rec_t;

endpackage

// File: rtl/cv32e41s_trace_ff_fifo.sv
// Generic synchronous FIFO, registered write, head entry presented combinationally.
module cv32e41s_trace_ff_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  T                mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? T'('0) : mem_q[rptr_q];

  // DEPTH is a power of two, so pointers wrap naturally
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_i) wptr_d = wptr_q + AW'(1);
    if (pop_i)  rptr_d = rptr_q + AW'(1);
    level_d = level_q + LW'(push_i) - LW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/cv32e41s_wb_trace_fifo.sv
// Turns WB retirements into trace records, buffers them, and tracks records
// lost to a full FIFO via a saturating drop counter and a gap marker.
module cv32e41s_wb_trace_fifo
  import cv32e41s_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ILLEGAL_ONLY = 0,
  parameter int unsigned SEQ_W        = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  ex_wb_pipe_t                 ex_wb_pipe_i,
  input  logic                        wb_valid_i,
  input  logic [31:0]                 mhartid_i,
  output logic                        rec_valid_o,
  input  logic                        rec_ready_i,
  output trace_rec_t                  rec_o,
  output logic [TRACE_DROP_CNT_W-1:0] drop_cnt_o,
  output logic [$clog2(DEPTH):0]      fifo_level_o
);

  localparam logic [TRACE_DROP_CNT_W-1:0] DROP_MAX = '1;

  logic                        retire, ev, push, pop, drop;
  logic                        full, empty;
  logic [SEQ_W-1:0]            seq_q, seq_d;
  logic                        gap_q, gap_d;
  logic [TRACE_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  trace_rec_t                  rec_in;
  logic [27:0]                 unused_hart;

  assign unused_hart = mhartid_i[31:4];

  assign retire = wb_valid_i & ex_wb_pipe_i.instr_valid;
  assign ev     = retire & ((ILLEGAL_ONLY == 0) | ex_wb_pipe_i.illegal_insn);
  assign pop    = ~empty & rec_ready_i;
  assign push   = ev & (~full | pop);
  assign drop   = ev & full & ~pop;

  always_comb begin
    rec_in         = '0;
    rec_in.seq     = TRACE_SEQ_W_MAX'(seq_q);
    rec_in.pc      = ex_wb_pipe_i.pc;
    rec_in.instr   = ex_wb_pipe_i.instr.bus_resp.rdata;
    rec_in.illegal = ex_wb_pipe_i.illegal_insn;
    rec_in.hart    = mhartid_i[TRACE_HART_W-1:0];
    rec_in.gap     = gap_q;
  end

  // Counter advances on filtered retirements too; drop beats accept for gap
  always_comb begin
    seq_d      = seq_q;
    gap_d      = gap_q;
    drop_cnt_d = drop_cnt_q;
    if (retire) seq_d = seq_q + SEQ_W'(1);
    if (drop) begin
      gap_d = 1'b1;
      if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + TRACE_DROP_CNT_W'(1);
    end else if (push) begin
      gap_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      gap_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      gap_q      <= gap_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  cv32e41s_trace_ff_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (pop),
    .data_o  (rec_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );

  assign rec_valid_o = ~empty;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/cv32e41s_wb_trace_fifo.md
Name: cv32e41s_wb_trace_fifo

Overview:
Sits downstream of the EX/WB pipeline register, next to the core log. Each instruction that leaves WB becomes a trace record: sequence number, PC, instruction word, illegal flag and hart ID. Records are buffered in a small FIFO and drained over a valid/ready port to the SoC debug/trace sink. Records that arrive while the FIFO is full are counted as drops. The next accepted record carries a gap flag so the sink can detect the loss.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
ILLEGAL_ONLY, 0, 1 = capture only records with illegal_insn set; 0 = capture every retired instruction
SEQ_W, 16, width of the retire sequence counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
ex_wb_pipe_i  in  ex_wb_pipe_t  EX/WB pipeline register contents
wb_valid_i  in  1  instruction in WB completes this cycle
mhartid_i  in  32  hart ID; only bits [3:0] are recorded
rec_valid_o  out  1  head record valid
rec_ready_i  in  1  sink accepts head record
rec_o  out  trace_rec_t  head record
drop_cnt_o  out  16  saturating count of dropped records
fifo_level_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: all of the following clear on the first rising edge with rst_i=1, regardless of any in-flight transfer. Contents are discarded.
  - rec_valid_o=0, rec_o=0, drop_cnt_o=0, fifo_level_o=0
  - sequence counter=0, gap flag=0
  - read and write pointers=0
- Capture event ev = wb_valid_i & ex_wb_pipe_i.instr_valid & (!ILLEGAL_ONLY | ex_wb_pipe_i.illegal_insn).
- Sequence counter:
  - Increments by 1 on every wb_valid_i & instr_valid, filtered or not. Wraps modulo 2^SEQ_W.
  - A record carries the counter value before the increment, so the first retirement after reset has seq=0.
- Record fields: seq, pc (ex_wb_pipe_i.pc), instr (ex_wb_pipe_i.instr.bus_resp.rdata), illegal (ex_wb_pipe_i.illegal_insn), hart (mhartid_i[3:0]), gap.
- Push:
  - When ev and (level<DEPTH or pop this cycle), the record is written at the write pointer and the write pointer advances, wrapping at DEPTH.
  - Write latency is 1 cycle: a record pushed into an empty FIFO shows rec_valid_o=1 on the next cycle. No fall-through.
- Pop:
  - A pop occurs when rec_valid_o & rec_ready_i. The read pointer advances on the next edge.
  - rec_o is driven combinationally from the head entry and holds stable while rec_valid_o=1 & !rec_ready_i.
- Full:
  - ev with level==DEPTH and no pop in the same cycle drops the record and sets gap.
  - drop_cnt_o increments and saturates at 16'hFFFF.
- Full with simultaneous pop: the push is accepted, level stays DEPTH, nothing is dropped.
- Empty: rec_valid_o=0 and rec_ready_i is ignored. A pop never happens in the same cycle as the push that fills an empty FIFO.
- Gap flag:
  - Copied into the next accepted record, then cleared in that cycle.
  - If a drop and an accept both occur in one cycle (impossible for a single event stream), drop takes priority.
- Level: level_next = level + push − pop. It never exceeds DEPTH and never underflows.
- drop_cnt_o is not cleared by draining. Only reset clears it.

Decomposition:
- cv32e41s_pkg gains:
  - trace_rec_t, a packed struct: seq[SEQ_W], pc[32], instr[32], illegal, hart[4], gap
  - TRACE_DROP_CNT_W = 16
- Sub-module cv32e41s_trace_ff_fifo: generic synchronous FIFO with push, pop, full, empty, level and a parameterised data type.
- The top holds the filter, sequence counter, gap and drop logic.

Test Plan:
- Reset with DEPTH=8: retire 3 instrs at pc 0x80, 0x84, 0x88, rec_ready_i=1 → 3 records with seq 0, 1, 2, gap=0, each rec_valid_o one cycle after its wb_valid_i.
- rec_ready_i=0, 10 consecutive retirements → level=8, drop_cnt_o=2. Raise ready, one more retirement → 9th record out has gap=1, seq=10; the earlier records have gap=0.
- Full FIFO, ready=1, retire in the same cycle → no drop, level stays 8, drop_cnt_o unchanged.
- ILLEGAL_ONLY=1: 5 retirements, only the 3rd illegal (pc 0x1008) → single record with seq=2, illegal=1, pc=0x1008.
- Seq wrap with SEQ_W=4: 17 retirements → 17th record seq=0.
- Assert rst_i mid-stream with level=5 and rec_valid_o=1 → next cycle level=0, rec_valid_o=0, drop_cnt_o=0, and the next capture has seq=0.
